// File: rtl/rk4_sequencer_if.sv
// Button inputs, step count and control strobes exchanged between the RK4
// sequencer and its surroundings (buttons, datapath mux, result/display regs).
interface rk4_sequencer_if #(
    parameter int N_WIDTH = 16
);
    logic               BTN_START;
    logic               BTN_RESTART;
    logic [N_WIDTH-1:0] N_STEPS;
    logic               SEL;
    logic               LD;
    logic               LD_DISP;
    logic               CLR;
    logic               BUSY;
    logic               DONE;
    logic [N_WIDTH-1:0] STEP;

    modport master (
        output BTN_START, BTN_RESTART, N_STEPS,
        input  SEL, LD, LD_DISP, CLR, BUSY, DONE, STEP
    );

    modport slave (
        input  BTN_START, BTN_RESTART, N_STEPS,
        output SEL, LD, LD_DISP, CLR, BUSY, DONE, STEP
    );
endinterface

// File: rtl/rk4_sequencer.sv
// Start/restart sequencer for the RK4 pipeline: times N iterations of the
// shift-register stages, then strobes result capture and display load.
module rk4_sequencer #(
    parameter int N_WIDTH      = 16,
    parameter int STAGE_CYCLES = 4,
    parameter int PH_WIDTH     = 3
) (
    input  logic          CLK,
    input  logic          RST_N,
    rk4_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_CAPTURE,
        S_DISPLAY,
        S_DONE,
        S_CLEAR
    } state_t;

    localparam logic [PH_WIDTH-1:0] PH_LAST  = PH_WIDTH'(STAGE_CYCLES - 1);
    localparam logic [N_WIDTH-1:0]  STEP_ONE = N_WIDTH'(1);

    state_t               state_reg;
    logic                 start_q_reg;
    logic                 restart_q_reg;
    logic [N_WIDTH-1:0]   n_reg;
    logic [N_WIDTH-1:0]   step_reg;
    logic [PH_WIDTH-1:0]  phase_reg;
    logic                 sel_reg;
    logic                 ld_reg;
    logic                 ld_disp_reg;
    logic                 clr_reg;
    logic                 busy_reg;
    logic                 done_reg;

    logic start_edge;
    logic restart_edge;

    assign start_edge   = bus.BTN_START   & ~start_q_reg;
    assign restart_edge = bus.BTN_RESTART & ~restart_q_reg;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_reg     <= S_IDLE;
            start_q_reg   <= 1'b0;
            restart_q_reg <= 1'b0;
            n_reg         <= '0;
            step_reg      <= '0;
            phase_reg     <= '0;
            sel_reg       <= 1'b0;
            ld_reg        <= 1'b0;
            ld_disp_reg   <= 1'b0;
            clr_reg       <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            start_q_reg   <= bus.BTN_START;
            restart_q_reg <= bus.BTN_RESTART;
            ld_reg        <= 1'b0;
            ld_disp_reg   <= 1'b0;
            clr_reg       <= 1'b0;

            // Restart outranks everything, including a coincident start edge.
            if (restart_edge && state_reg != S_CLEAR) begin
                state_reg <= S_CLEAR;
                clr_reg   <= 1'b1;
                busy_reg  <= 1'b0;
                done_reg  <= 1'b0;
                sel_reg   <= 1'b0;
                step_reg  <= '0;
                phase_reg <= '0;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (start_edge) begin
                            step_reg  <= '0;
                            phase_reg <= '0;
                            if (bus.N_STEPS != '0) begin
                                n_reg     <= bus.N_STEPS;
                                state_reg <= S_RUN;
                                busy_reg  <= 1'b1;
                                sel_reg   <= 1'b0;
                            end else begin
                                state_reg <= S_DONE;
                                done_reg  <= 1'b1;
                                sel_reg   <= 1'b1;
                            end
                        end
                    end
                    S_RUN: begin
                        if (phase_reg == PH_LAST) begin
                            phase_reg <= '0;
                            if (step_reg == n_reg - STEP_ONE) begin
                                state_reg <= S_CAPTURE;
                                busy_reg  <= 1'b0;
                                ld_reg    <= 1'b1;
                                sel_reg   <= 1'b1;
                            end else begin
                                // Iterations after the first feed back x_rk4/y_rk4.
                                step_reg <= step_reg + STEP_ONE;
                                sel_reg  <= 1'b1;
                            end
                        end else begin
                            phase_reg <= phase_reg + 1'b1;
                        end
                    end
                    S_CAPTURE: begin
                        state_reg   <= S_DISPLAY;
                        ld_disp_reg <= 1'b1;
                    end
                    S_DISPLAY: begin
                        state_reg <= S_DONE;
                        done_reg  <= 1'b1;
                    end
                    S_DONE: begin
                        state_reg <= S_DONE;
                    end
                    S_CLEAR: begin
                        state_reg <= S_IDLE;
                    end
                    default: begin
                        state_reg <= S_IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b0;
                        sel_reg   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.SEL     = sel_reg;
    assign bus.LD      = ld_reg;
    assign bus.LD_DISP = ld_disp_reg;
    assign bus.CLR     = clr_reg;
    assign bus.BUSY    = busy_reg;
    assign bus.DONE    = done_reg;
    assign bus.STEP    = step_reg;
endmodule

// File: tb/tb_rk4_sequencer.sv
// Directed bench for rk4_sequencer: a timeline model predicts every output
// each cycle, and literal cycle numbers pin the model's latencies.
module tb_rk4_sequencer;
    localparam int NW = 16;
    localparam int SC = 4;
    localparam int MD_IDLE = 0;
    localparam int MD_RUN  = 1;
    localparam int MD_CLR  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rk4_sequencer_if #(.N_WIDTH(NW)) bus ();

    rk4_sequencer #(
        .N_WIDTH(NW),
        .STAGE_CYCLES(SC),
        .PH_WIDTH(3)
    ) dut (
        .CLK(clk),
        .RST_N(rst_n),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;

    // Model: a started run is a timeline measured from its start edge.
    int cyc = 0;
    int m_mode = MD_IDLE;
    int m_t0 = 0;
    int m_n = 0;
    logic m_sq = 1'b0;
    logic m_rq = 1'b0;
    logic m_valid = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            m_mode  <= MD_IDLE;
            m_sq    <= 1'b0;
            m_rq    <= 1'b0;
            m_valid <= 1'b1;
        end else begin
            m_sq <= bus.BTN_START;
            m_rq <= bus.BTN_RESTART;
            if (m_mode == MD_IDLE) begin
                if (bus.BTN_RESTART && !m_rq) begin
                    m_mode <= MD_CLR;
                end else if (bus.BTN_START && !m_sq) begin
                    m_mode <= MD_RUN;
                    m_t0   <= cyc + 1;
                    m_n    <= int'(bus.N_STEPS);
                end
            end else if (m_mode == MD_RUN) begin
                if (bus.BTN_RESTART && !m_rq) m_mode <= MD_CLR;
            end else begin
                m_mode <= MD_IDLE;
            end
        end
    end

    // Event records, written only by tick().
    int ld_cyc = -1, ldd_cyc = -1, clr_cyc = -1, done_rise = -1, sel_rise = -1;
    int ld_count = 0, ldd_count = 0, clr_count = 0, busy_count = 0;
    logic prev_done = 1'b0, prev_sel = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        int e, c;
        int x_sel, x_ld, x_ldd, x_clr, x_busy, x_done, x_step;
        logic [NW+5:0] act, expv;
        @(negedge clk);
        c = cyc + 1;
        if (m_valid) begin
            x_sel = 0; x_ld = 0; x_ldd = 0; x_clr = 0; x_busy = 0; x_done = 0; x_step = 0;
            if (m_mode == MD_CLR) begin
                x_clr = 1;
            end else if (m_mode == MD_RUN) begin
                e = c - m_t0;
                if (m_n == 0) begin
                    x_done = 1; x_sel = 1;
                end else if (e <= SC * m_n) begin
                    x_busy = 1;
                    x_step = (e - 1) / SC;
                    x_sel = (x_step != 0) ? 1 : 0;
                end else begin
                    x_step = m_n - 1;
                    x_sel = 1;
                    if (e == SC * m_n + 1) x_ld = 1;
                    else if (e == SC * m_n + 2) x_ldd = 1;
                    else x_done = 1;
                end
            end
            act  = {bus.SEL, bus.LD, bus.LD_DISP, bus.CLR, bus.BUSY, bus.DONE, bus.STEP};
            expv = {x_sel[0], x_ld[0], x_ldd[0], x_clr[0], x_busy[0], x_done[0], NW'(x_step)};
            checks++;
            if (act !== expv) begin
                failures++;
                $display("FAIL model_cycle%0d actual={sel,ld,ldd,clr,busy,done,step}=%h required=%h",
                         c, act, expv);
            end
            if (bus.LD === 1'b1) begin ld_cyc = c; ld_count++; end
            if (bus.LD_DISP === 1'b1) begin ldd_cyc = c; ldd_count++; end
            if (bus.CLR === 1'b1) begin clr_cyc = c; clr_count++; end
            if (bus.BUSY === 1'b1) busy_count++;
            if (bus.DONE === 1'b1 && prev_done !== 1'b1) done_rise = c;
            if (bus.SEL === 1'b1 && prev_sel !== 1'b1) sel_rise = c;
            prev_done = bus.DONE;
            prev_sel = bus.SEL;
        end
        #1;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k = 0;
        while (bus.DONE !== 1'b1 && k < budget) begin
            tick();
            k++;
        end
        chk(name, int'(bus.DONE === 1'b1), 1);
    endtask

    task automatic pulse_restart();
        bus.BTN_RESTART = 1'b1;
        tick();
        tick();
        bus.BTN_RESTART = 1'b0;
        tick();
    endtask

    int t, r, k0, b0;

    initial begin
        bus.BTN_START = 1'b1;
        bus.BTN_RESTART = 1'b0;
        bus.N_STEPS = NW'(10);
        rst_n = 1'b0;
        repeat (3) tick();
        chk("reset_busy", int'(bus.BUSY), 0);
        chk("reset_step", int'(bus.STEP), 0);
        chk("reset_done", int'(bus.DONE), 0);

        // Start held through reset: the first post-reset edge starts a 10-step run.
        rst_n = 1'b1;
        t = cyc + 1;
        tick();
        chk("held_start_busy", int'(bus.BUSY), 1);
        chk("held_start_sel", int'(bus.SEL), 0);
        chk("held_start_step", int'(bus.STEP), 0);
        wait_done("n10_done_reached", 80);
        tick();
        tick();
        chk("n10_sel_rise", sel_rise, t + 5);
        chk("n10_ld_cycle", ld_cyc, t + 41);
        chk("n10_ld_disp_cycle", ldd_cyc, t + 42);
        chk("n10_done_rise", done_rise, t + 43);
        chk("n10_ld_count", ld_count, 1);
        $display("run n=10 start=%0d ld=%0d ld_disp=%0d done=%0d", t, ld_cyc, ldd_cyc, done_rise);

        bus.BTN_START = 1'b0;
        bus.BTN_RESTART = 1'b1;
        r = cyc + 1;
        tick();
        tick();
        bus.BTN_RESTART = 1'b0;
        tick();
        chk("done_restart_clr_cycle", clr_cyc, r + 1);
        chk("done_restart_idle", int'(bus.DONE), 0);
        $display("restart from done edge=%0d clr=%0d", r, clr_cyc);

        // Start held for 100 cycles gives a single run; later N_STEPS changes are ignored.
        bus.N_STEPS = NW'(2);
        bus.BTN_START = 1'b1;
        t = cyc + 1;
        for (int i = 0; i < 100; i++) begin
            if (i == 3) bus.N_STEPS = NW'(7);
            tick();
        end
        chk("held_n2_ld_cycle", ld_cyc, t + 9);
        chk("held_n2_ld_count", ld_count, 2);
        chk("held_n2_done", int'(bus.DONE), 1);
        $display("run n=2 held start=%0d ld=%0d", t, ld_cyc);
        bus.BTN_START = 1'b0;
        pulse_restart();

        // Abort mid-run at STEP 3.
        bus.N_STEPS = NW'(10);
        bus.BTN_START = 1'b1;
        t = cyc + 1;
        tick();
        bus.BTN_START = 1'b0;
        k0 = 0;
        while (bus.STEP !== NW'(3) && k0 < 40) begin
            tick();
            k0++;
        end
        chk("abort_reached_step3", int'(bus.STEP === NW'(3)), 1);
        bus.BTN_RESTART = 1'b1;
        r = cyc + 1;
        repeat (3) tick();
        bus.BTN_RESTART = 1'b0;
        chk("abort_clr_cycle", clr_cyc, r + 1);
        chk("abort_no_ld", ld_count, 2);
        chk("abort_step", int'(bus.STEP), 0);
        chk("abort_sel", int'(bus.SEL), 0);
        chk("abort_busy", int'(bus.BUSY), 0);
        $display("abort run start=%0d restart=%0d clr=%0d", t, r, clr_cyc);

        // Zero-step start goes straight to DONE.
        bus.N_STEPS = '0;
        bus.BTN_START = 1'b1;
        t = cyc + 1;
        k0 = clr_count;
        tick();
        tick();
        bus.BTN_START = 1'b0;
        chk("n0_done_rise", done_rise, t + 1);
        chk("n0_no_ld", ld_count, 2);
        chk("n0_no_ld_disp", ldd_count, 2);
        chk("n0_no_clr", clr_count, k0);
        r = cyc + 1;
        pulse_restart();
        chk("n0_restart_clr_cycle", clr_cyc, r + 1);
        chk("n0_restart_clr_count", clr_count, k0 + 1);
        chk("n0_restart_idle", int'(bus.DONE), 0);
        $display("run n=0 start=%0d done=%0d clr=%0d", t, done_rise, clr_cyc);

        // Coincident start and restart from IDLE: restart wins, no run.
        bus.N_STEPS = NW'(5);
        b0 = busy_count;
        bus.BTN_START = 1'b1;
        bus.BTN_RESTART = 1'b1;
        t = cyc + 1;
        repeat (3) tick();
        bus.BTN_START = 1'b0;
        bus.BTN_RESTART = 1'b0;
        tick();
        chk("both_clr_cycle", clr_cyc, t + 1);
        chk("both_no_run", busy_count, b0);
        chk("both_idle_done", int'(bus.DONE), 0);

        bus.N_STEPS = NW'(1);
        bus.BTN_START = 1'b1;
        t = cyc + 1;
        wait_done("n1_done_reached", 20);
        tick();
        bus.BTN_START = 1'b0;
        chk("n1_ld_cycle", ld_cyc, t + 5);
        chk("n1_done_rise", done_rise, t + 7);
        $display("run n=1 start=%0d ld=%0d done=%0d", t, ld_cyc, done_rise);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
